// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller
//
// Time-multiplexes one shared 8-line segment bus across NUM_DIGITS common-anode 7-segment digits.
// Each rising edge of the (slow) scan clock fnd_clk advances to the next digit, with a dark
// blanking gap of BLANK_CYCLES clock_50m cycles before every digit to prevent ghosting.
// Optional leading-zero suppression. All outputs are registered.
//
// Ports:
//   clock_50m   in   50 MHz board clock
//   rst         in   asynchronous reset, active-low
//   fnd_clk     in   scan clock, sampled as data through a 2-flop synchronizer
//   enable      in   1 = scan, 0 = display dark
//   digits_bcd  in   digit i at [4i+3:4i], digit 0 is the rightmost
//   dp_in       in   decimal point per digit, 1 = lit
//   blank_lz    in   1 = suppress leading zeros
//   fnd_com     out  digit select, active-low, at most one bit low
//   fnd_seg     out  [0]=a .. [6]=g, [7]=dp, active-high
//   scan_idx    out  index of the digit currently owning the bus

module fnd_scan_controller #(
  parameter int unsigned NUM_DIGITS   = 6,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                      clock_50m,
  input  logic                      rst,
  input  logic                      fnd_clk,
  input  logic                      enable,
  input  logic [4*NUM_DIGITS-1:0]   digits_bcd,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      blank_lz,
  output logic [NUM_DIGITS-1:0]     fnd_com,
  output logic [7:0]                fnd_seg,
  output logic [2:0]                scan_idx
);

  localparam int unsigned CntW = $clog2(BLANK_CYCLES + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(BLANK_CYCLES - 1);
  localparam logic [2:0] LastIdx = 3'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [2:0]              idx_q, idx_d;
  logic [NUM_DIGITS-1:0]   com_q, com_d;
  logic [7:0]              seg_q, seg_d;
  logic                    sync1_q, sync2_q, hist_q;
  logic                    tick;

  logic [3:0]              sel_digit;
  logic                    sel_dp;
  logic                    upper_nz;
  logic                    lz_blank;
  logic [7:0]              show_seg;
  logic [NUM_DIGITS-1:0]   show_com;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Rising-edge detect on the synchronized scan clock; one clock_50m cycle wide.
  assign tick = sync2_q & ~hist_q;

  // Slot contents for the current index, sampled only on the SHOW entry edge.
  always_comb begin
    sel_digit = 4'h0;
    sel_dp    = 1'b0;
    upper_nz  = 1'b0;
    show_com  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (3'(i) == idx_q) begin
        sel_digit   = digits_bcd[4*i +: 4];
        sel_dp      = dp_in[i];
        show_com[i] = 1'b0;
      end
      // Any nonzero digit at or above the current one keeps it visible.
      if (3'(i) >= idx_q && digits_bcd[4*i +: 4] != 4'h0) begin
        upper_nz = 1'b1;
      end
    end
    lz_blank = blank_lz && (idx_q != 3'd0) && !upper_nz;
    show_seg = {sel_dp, lz_blank ? 7'h00 : decode(sel_digit)};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    com_d   = com_q;
    seg_d   = seg_q;
    if (!enable) begin
      // Disable wins over a simultaneous tick; index is held for re-enable.
      state_d = StIdle;
      com_d   = '1;
      seg_d   = 8'h00;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StBlank;
          cnt_d   = CntLoad;
          com_d   = '1;
          seg_d   = 8'h00;
        end
        StBlank: begin
          // Ticks here are dropped on purpose.
          com_d = '1;
          seg_d = 8'h00;
          if (cnt_q == '0) begin
            state_d = StShow;
            com_d   = show_com;
            seg_d   = show_seg;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        StShow: begin
          if (tick) begin
            state_d = StBlank;
            cnt_d   = CntLoad;
            com_d   = '1;
            seg_d   = 8'h00;
            idx_d   = (idx_q == LastIdx) ? 3'd0 : idx_q + 3'd1;
          end
        end
        default: begin
          state_d = StIdle;
          com_d   = '1;
          seg_d   = 8'h00;
        end
      endcase
    end
  end

  always_ff @(posedge clock_50m or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      com_q   <= '1;
      seg_q   <= 8'h00;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      com_q   <= com_d;
      seg_q   <= seg_d;
      sync1_q <= fnd_clk;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign fnd_com  = com_q;
  assign fnd_seg  = seg_q;
  assign scan_idx = idx_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller: directed scenarios plus randomized slots, checked against a
// slot-level reference model (decode table lookup and arithmetic leading-zero rule).

module tb_fnd_scan_controller;

  localparam int NumDigits = 6;
  localparam int BlankCyc  = 500;

  logic                     clk;
  logic                     rst;
  logic                     fnd_clk;
  logic                     enable;
  logic [4*NumDigits-1:0]   digits_bcd;
  logic [NumDigits-1:0]     dp_in;
  logic                     blank_lz;
  logic [NumDigits-1:0]     fnd_com;
  logic [7:0]               fnd_seg;
  logic [2:0]               scan_idx;

  int n_vec = 0;
  int n_bad = 0;
  int exp_idx = 0;
  logic [7:0]           held_seg;
  logic [NumDigits-1:0] held_com;
  logic [6:0] seg_tab [16];

  fnd_scan_controller #(
    .NUM_DIGITS  (NumDigits),
    .BLANK_CYCLES(BlankCyc)
  ) dut (
    .clock_50m (clk),
    .rst       (rst),
    .fnd_clk   (fnd_clk),
    .enable    (enable),
    .digits_bcd(digits_bcd),
    .dp_in     (dp_in),
    .blank_lz  (blank_lz),
    .fnd_com   (fnd_com),
    .fnd_seg   (fnd_seg),
    .scan_idx  (scan_idx)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // At most one digit selected, every cycle.
  always @(negedge clk) begin
    check_eq("com_onehot", 32'($countones(~fnd_com) <= 1), 32'd1);
  end

  function automatic logic [7:0] model_seg(input int idx);
    logic [3:0] v;
    logic       lead;
    v    = 4'(digits_bcd >> (4 * idx));
    lead = blank_lz && (idx != 0) && ((digits_bcd >> (4 * idx)) == '0);
    return {dp_in[idx], lead ? 7'h00 : seg_tab[v]};
  endfunction

  function automatic logic [NumDigits-1:0] model_com(input int idx);
    logic [NumDigits-1:0] c;
    c = '1;
    c[idx] = 1'b0;
    return c;
  endfunction

  task automatic check_slot();
    held_seg = model_seg(exp_idx);
    held_com = model_com(exp_idx);
    check_eq("scan_idx", 32'(scan_idx), 32'(exp_idx));
    check_eq("fnd_com", 32'(fnd_com), 32'(held_com));
    check_eq("fnd_seg", 32'(fnd_seg), 32'(held_seg));
  endtask

  // Count dark negedges from now until a digit lights, bounded.
  task automatic wait_lit(output int dark);
    dark = 0;
    while (fnd_com == '1 && dark < 3000) begin
      dark++;
      @(negedge clk);
    end
    check_eq("lit_seen", 32'(fnd_com != '1), 32'd1);
  endtask

  // From a lit SHOW slot: pulse fnd_clk, check latency and gap, check the next slot.
  task automatic do_slot(input bit inject);
    int lit_cnt;
    int dark;
    fnd_clk = 1'b1;
    lit_cnt = 0;
    while (fnd_com != '1 && lit_cnt < 10) begin
      @(negedge clk);
      lit_cnt++;
    end
    check_eq("tick_latency", 32'(lit_cnt), 32'd3);
    fnd_clk = 1'b0;
    dark = 0;
    while (fnd_com == '1 && dark < 3000) begin
      dark++;
      if (inject && dark == 100) fnd_clk = 1'b1;
      if (inject && dark == 110) fnd_clk = 1'b0;
      @(negedge clk);
    end
    check_eq("lit_seen", 32'(fnd_com != '1), 32'd1);
    check_eq("dark_cycles", 32'(dark), 32'(BlankCyc));
    exp_idx = (exp_idx + 1) % NumDigits;
    check_slot();
  endtask

  task automatic randomize_inputs();
    logic [23:0] r;
    r          = 24'($urandom());
    digits_bcd = r >> (4 * $urandom_range(0, 5));
    dp_in      = 6'($urandom());
    blank_lz   = 1'($urandom());
  endtask

  initial begin
    int dark;
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    rst        = 1'b0;
    fnd_clk    = 1'b0;
    enable     = 1'b0;
    digits_bcd = '0;
    dp_in      = '0;
    blank_lz   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_com", 32'(fnd_com), 32'h3F);
    check_eq("rst_seg", 32'(fnd_seg), 32'h00);
    check_eq("rst_idx", 32'(scan_idx), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_com", 32'(fnd_com), 32'h3F);

    // Basic scan with wrap
    digits_bcd = 24'h654321;
    enable = 1'b1;
    wait_lit(dark);
    check_eq("enable_dark", 32'(dark), 32'(BlankCyc + 1));
    exp_idx = 0;
    check_slot();
    for (int i = 0; i < 7; i++) do_slot(1'b0);

    // Leading-zero blanking with a decimal point, then without blanking
    digits_bcd = 24'h000042;
    dp_in      = 6'b000100;
    blank_lz   = 1'b1;
    for (int i = 0; i < NumDigits; i++) do_slot(1'b0);
    blank_lz = 1'b0;
    for (int i = 0; i < NumDigits; i++) do_slot(1'b0);

    // Hex digits on digit 0, then a tick injected during blanking
    dp_in = '0;
    digits_bcd = 24'h00000A;
    for (int i = 0; i < NumDigits; i++) do_slot(1'b0);
    digits_bcd = 24'h00000F;
    for (int i = 0; i < NumDigits; i++) do_slot(1'b0);
    do_slot(1'b1);
    do_slot(1'b0);

    // Disable on the same edge as a tick
    fnd_clk = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("dis_com", 32'(fnd_com), 32'h3F);
    check_eq("dis_seg", 32'(fnd_seg), 32'h00);
    check_eq("dis_idx", 32'(scan_idx), 32'(exp_idx));
    fnd_clk = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("dis_hold_com", 32'(fnd_com), 32'h3F);
    enable = 1'b1;
    wait_lit(dark);
    check_eq("reen_dark", 32'(dark), 32'(BlankCyc + 1));
    check_slot();

    // Asynchronous reset mid-SHOW
    do_slot(1'b0);
    #5 rst = 1'b0;
    #1;
    check_eq("arst_com", 32'(fnd_com), 32'h3F);
    check_eq("arst_seg", 32'(fnd_seg), 32'h00);
    check_eq("arst_idx", 32'(scan_idx), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_idx = 0;
    wait_lit(dark);
    check_eq("post_rst_dark", 32'(dark), 32'(BlankCyc + 1));
    check_slot();

    // Randomized slots; inputs change while a slot is shown and must not leak into it
    for (int n = 0; n < 30; n++) begin
      randomize_inputs();
      repeat (3) @(negedge clk);
      check_eq("hold_com", 32'(fnd_com), 32'(held_com));
      check_eq("hold_seg", 32'(fnd_seg), 32'(held_seg));
      do_slot(($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
